// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronizes and debounces a raw key, classifies each press
// as dot or dash, and turns a completed element sequence into an ASCII code.
module morse_key_decoder #(
    parameter int UNIT_CYCLES     = 5_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_ELEMS       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [7:0] code,
    output logic       flag,
    output logic       err,
    output logic       busy
);
    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT_CYCLES);
    localparam logic [CW-1:0] GAP_END  = CW'(3 * UNIT_CYCLES);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    NEL_MAX  = 3'(MAX_ELEMS);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

    state_t          state_q;
    logic            key_s1_q, key_s2_q, kd_q;
    logic [DW-1:0]   db_cnt_q;
    logic [CW-1:0]   len_q, gap_q;
    logic [4:0]      pat_q;
    logic [2:0]      nel_q;
    logic            ovf_q;
    logic [7:0]      code_q;
    logic            flag_q, err_q, busy_q;
    logic [8:0]      lut;

    assign code = code_q;
    assign flag = flag_q;
    assign err  = err_q;
    assign busy = busy_q;

    // Key is {nel, pat}; pat holds the first element in bit 0, 1 = dash.
    function automatic logic [8:0] decode(input logic [7:0] k);
        case (k)
            {3'd1, 5'b00000}: decode = {1'b1, "E"};
            {3'd1, 5'b00001}: decode = {1'b1, "T"};
            {3'd2, 5'b00010}: decode = {1'b1, "A"};
            {3'd2, 5'b00000}: decode = {1'b1, "I"};
            {3'd2, 5'b00011}: decode = {1'b1, "M"};
            {3'd2, 5'b00001}: decode = {1'b1, "N"};
            {3'd3, 5'b00001}: decode = {1'b1, "D"};
            {3'd3, 5'b00011}: decode = {1'b1, "G"};
            {3'd3, 5'b00101}: decode = {1'b1, "K"};
            {3'd3, 5'b00111}: decode = {1'b1, "O"};
            {3'd3, 5'b00010}: decode = {1'b1, "R"};
            {3'd3, 5'b00000}: decode = {1'b1, "S"};
            {3'd3, 5'b00100}: decode = {1'b1, "U"};
            {3'd3, 5'b00110}: decode = {1'b1, "W"};
            {3'd4, 5'b00001}: decode = {1'b1, "B"};
            {3'd4, 5'b00101}: decode = {1'b1, "C"};
            {3'd4, 5'b00100}: decode = {1'b1, "F"};
            {3'd4, 5'b00000}: decode = {1'b1, "H"};
            {3'd4, 5'b01110}: decode = {1'b1, "J"};
            {3'd4, 5'b00010}: decode = {1'b1, "L"};
            {3'd4, 5'b00110}: decode = {1'b1, "P"};
            {3'd4, 5'b01011}: decode = {1'b1, "Q"};
            {3'd4, 5'b01000}: decode = {1'b1, "V"};
            {3'd4, 5'b01001}: decode = {1'b1, "X"};
            {3'd4, 5'b01101}: decode = {1'b1, "Y"};
            {3'd4, 5'b00011}: decode = {1'b1, "Z"};
            {3'd5, 5'b11111}: decode = {1'b1, "0"};
            {3'd5, 5'b11110}: decode = {1'b1, "1"};
            {3'd5, 5'b11100}: decode = {1'b1, "2"};
            {3'd5, 5'b11000}: decode = {1'b1, "3"};
            {3'd5, 5'b10000}: decode = {1'b1, "4"};
            {3'd5, 5'b00000}: decode = {1'b1, "5"};
            {3'd5, 5'b00001}: decode = {1'b1, "6"};
            {3'd5, 5'b00011}: decode = {1'b1, "7"};
            {3'd5, 5'b00111}: decode = {1'b1, "8"};
            {3'd5, 5'b01111}: decode = {1'b1, "9"};
            default:          decode = 9'h0FF;
        endcase
    endfunction

    always_comb lut = decode({nel_q, pat_q});

    // kd only flips after the synchronized key disagrees for DEBOUNCE_CYCLES straight clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_s1_q <= 1'b0;
            key_s2_q <= 1'b0;
            kd_q     <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            if (key_s2_q != kd_q) begin
                if (db_cnt_q == DB_LAST) begin
                    kd_q     <= key_s2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
            nel_q   <= '0;
            ovf_q   <= 1'b0;
            code_q  <= 8'hFF;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
            if (kd_q) len_q <= (len_q == GAP_END) ? len_q : len_q + 1'b1;
            else      len_q <= '0;
            case (state_q)
                IDLE: if (kd_q) begin
                    state_q <= PRESS;
                    busy_q  <= 1'b1;
                end
                PRESS: if (!kd_q) begin
                    if (nel_q == NEL_MAX) begin
                        ovf_q <= 1'b1;
                    end else begin
                        pat_q[nel_q] <= (len_q >= DASH_MIN);
                        nel_q        <= nel_q + 1'b1;
                    end
                    gap_q   <= CW'(1);
                    state_q <= GAP;
                end
                // End of letter gap beats a simultaneous re-press.
                GAP: if (gap_q == GAP_END) begin
                    state_q <= EMIT;
                    if (!ovf_q && lut[8]) begin
                        code_q <= lut[7:0];
                        flag_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else if (kd_q) begin
                    gap_q   <= '0;
                    state_q <= PRESS;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
                EMIT: begin
                    pat_q   <= '0;
                    nel_q   <= '0;
                    ovf_q   <= 1'b0;
                    gap_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with short unit and debounce times.
module tb_morse_key_decoder;
    localparam int U = 10;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic [7:0] code;
    logic       flag, err, busy;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_flag = 0, n_err = 0, n_both = 0, flag_cyc = 0;
    int f0, e0, rel;

    always #5 clk = ~clk;

    morse_key_decoder #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(D), .MAX_ELEMS(5)) dut (
        .clk(clk), .rst(rst), .key(key),
        .code(code), .flag(flag), .err(err), .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flag) begin
            n_flag   <= n_flag + 1;
            flag_cyc <= cyc;
        end
        if (err) n_err <= n_err + 1;
        if (flag && err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int n);
        key = 1'b1;
        tick(n);
        key = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_code", int'(code), 'hFF);
        chk("rst_flag", int'(flag), 0);
        chk("rst_err",  int'(err),  0);
        chk("rst_busy", int'(busy), 0);
        tick(3);
        rst = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 200; i++) begin
            tick(1);
            chk("idle_outs", int'({code, flag, err, busy}), int'({8'hFF, 3'b000}));
        end

        // 2: S with latency check
        f0 = n_flag;
        press(10); tick(10); press(10); tick(10); press(10);
        rel = cyc;
        tick(60);
        chk("S_flags", n_flag - f0, 1);
        chk("S_code", int'(code), 'h53);
        chk("S_latency", flag_cyc - rel, 2 + D + 3 * U + 1);
        chk("S_busy_after", int'(busy), 0);

        // 3: Y then E, code held in between
        f0 = n_flag;
        press(30); tick(10); press(10); tick(10); press(30); tick(10); press(30);
        tick(60);
        chk("Y_flags", n_flag - f0, 1);
        chk("Y_code", int'(code), 'h59);
        press(10); tick(5);
        chk("E_hold_code", int'(code), 'h59);
        chk("E_busy", int'(busy), 1);
        tick(60);
        chk("E_flags", n_flag - f0, 2);
        chk("E_code", int'(code), 'h45);

        // 4: overflow and invalid 4-element pattern
        f0 = n_flag; e0 = n_err;
        for (int i = 0; i < 6; i++) begin
            press(10); tick(10);
        end
        tick(60);
        chk("ovf_err", n_err - e0, 1);
        chk("ovf_flag", n_flag - f0, 0);
        chk("ovf_code", int'(code), 'h45);
        press(10); tick(10); press(10); tick(10); press(30); tick(10); press(30);
        tick(60);
        chk("inv_err", n_err - e0, 2);
        chk("inv_flag", n_flag - f0, 0);
        chk("inv_code", int'(code), 'h45);

        // 5: bounce shorter than the debounce window
        f0 = n_flag; e0 = n_err;
        for (int i = 0; i < 5; i++) begin
            key = 1'b1; tick(2);
            key = 1'b0; tick(2);
            chk("bounce_busy", int'(busy), 0);
        end
        tick(60);
        chk("bounce_flag", n_flag - f0, 0);
        chk("bounce_err", n_err - e0, 0);
        chk("bounce_busy_end", int'(busy), 0);

        // gap of 3U-1 continues the character; 3U ends it
        f0 = n_flag;
        press(10); tick(3 * U - 1); press(10);
        tick(60);
        chk("gap29_flags", n_flag - f0, 1);
        chk("gap29_code", int'(code), 'h49);
        press(10); tick(3 * U); press(10);
        tick(60);
        chk("gap30_flags", n_flag - f0, 3);
        chk("gap30_code", int'(code), 'h45);

        // very long hold saturates and still reads as a dash
        press(200); tick(10); press(10);
        tick(60);
        chk("long_code", int'(code), 'h4E);

        // 6: reset during GAP
        press(10); tick(10); press(10); tick(15);
        rst = 1'b0;
        #1;
        chk("mid_rst_code", int'(code), 'hFF);
        chk("mid_rst_flag", int'(flag), 0);
        chk("mid_rst_err",  int'(err),  0);
        chk("mid_rst_busy", int'(busy), 0);
        tick(3);
        rst = 1'b1;
        f0 = n_flag; e0 = n_err;
        tick(60);
        chk("post_rst_flag", n_flag - f0, 0);
        chk("post_rst_err", n_err - e0, 0);
        press(30);
        tick(60);
        chk("T_flags", n_flag - f0, 1);
        chk("T_code", int'(code), 'h54);
        chk("flag_err_excl", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
